// File: rtl/shift_reg_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_seq_ctrl
//  Purpose  : Command sequencer driving a 4-bit shifting register through
//             load / shift / load+shift / rotate commands.
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_fb,
    output logic             enb,
    output logic [1:0]       modo,
    output logic             s_in,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_op_load      = 2'b00;
    localparam logic [1:0] c_op_rotate    = 2'b11;
    localparam logic [1:0] c_mode_hold    = 2'b00;
    localparam logic [1:0] c_mode_left    = 2'b01;
    localparam logic [1:0] c_mode_right   = 2'b10;
    localparam logic [1:0] c_mode_load    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_fill;
    logic [CNT_W-1:0] r_rem;

    logic             r_enb;
    logic [1:0]       r_modo;
    logic             r_sin_fill;
    logic             r_rot_active;
    logic [WIDTH-1:0] r_d;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_rot_bit;

    assign cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // Rotate feeds the bit falling off one end straight back into the other.
    assign w_rot_bit = r_dir ? q_fb[0] : q_fb[WIDTH-1];

    assign enb  = r_enb;
    assign modo = r_modo;
    assign s_in = r_rot_active ? w_rot_bit : r_sin_fill;
    assign d    = r_d;
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_dir        <= 1'b0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_fill       <= 1'b0;
            r_rem        <= '0;
            r_enb        <= 1'b0;
            r_modo       <= c_mode_hold;
            r_sin_fill   <= 1'b0;
            r_rot_active <= 1'b0;
            r_d          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_dir  <= cmd_dir;
                        r_cnt  <= cmd_cnt;
                        r_data <= cmd_data;
                        r_fill <= cmd_fill;
                        r_busy <= 1'b1;
                        if (!cmd_op[0]) begin
                            r_state <= ST_LOAD;
                            r_enb   <= 1'b1;
                            r_modo  <= c_mode_load;
                            r_d     <= cmd_data;
                        end else if (cmd_cnt != '0) begin
                            r_state      <= ST_SHIFT;
                            r_rem        <= cmd_cnt;
                            r_enb        <= 1'b1;
                            r_modo       <= cmd_dir ? c_mode_right : c_mode_left;
                            r_rot_active <= (cmd_op == c_op_rotate);
                            r_sin_fill   <= (cmd_op == c_op_rotate) ? 1'b0 : cmd_fill;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    r_d <= '0;
                    if ((r_op == c_op_load) || (r_cnt == '0)) begin
                        r_state <= ST_DONE;
                        r_enb   <= 1'b0;
                        r_modo  <= c_mode_hold;
                        r_done  <= 1'b1;
                    end else begin
                        // Load+shift continues with the shift phase; never a rotate.
                        r_state      <= ST_SHIFT;
                        r_rem        <= r_cnt;
                        r_modo       <= r_dir ? c_mode_right : c_mode_left;
                        r_rot_active <= 1'b0;
                        r_sin_fill   <= r_fill;
                    end
                end

                ST_SHIFT: begin
                    r_rem <= r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        r_state      <= ST_DONE;
                        r_enb        <= 1'b0;
                        r_modo       <= c_mode_hold;
                        r_rot_active <= 1'b0;
                        r_sin_fill   <= 1'b0;
                        r_done       <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_seq_ctrl
//  Purpose  : Directed self-checking bench; includes a behavioural 4-bit
//             shifting register closing the Q feedback loop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_reg_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic       cmd_dir = 1'b0;
    logic [2:0] cmd_cnt = '0;
    logic [3:0] cmd_data = '0;
    logic       cmd_fill = 1'b0;
    logic [3:0] q = '0;
    logic       enb;
    logic [1:0] modo;
    logic       s_in;
    logic [3:0] d;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    shift_reg_seq_ctrl #(.WIDTH(4), .CNT_W(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .q_fb      (q),
        .enb       (enb),
        .modo      (modo),
        .s_in      (s_in),
        .d         (d),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Register model; it is not reset so contents survive an aborted command.
    always_ff @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b01:   q <= {q[2:0], s_in};
                2'b10:   q <= {s_in, q[3:1]};
                2'b11:   q <= d;
                default: q <= q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] out_vec();
        return {cmd_ready, enb, modo, s_in, d, busy, done};
    endfunction

    // Issues one command from IDLE and follows it to its DONE pulse.
    task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [2:0] cnt,
                           input logic [3:0] data, input logic fill,
                           output int lat, output int nenb, output int nbusy,
                           output logic [7:0] snap);
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = 4'($urandom);
        cmd_fill  = 1'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_cnt   = 3'($urandom);
        cmd_op    = 2'($urandom);
        lat   = 1;
        nenb  = 0;
        nbusy = 0;
        snap  = {enb, modo, s_in, d};
        forever begin
            nenb  += int'(enb);
            nbusy += int'(busy);
            if (done) break;
            if (lat >= 20) begin
                check("timeout", 32'(lat), 32'd0);
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        check("ready_after_done", 32'(cmd_ready), 32'd1);
    endtask

    int         lat, nenb, nbusy, acc, dn, bad;
    logic [7:0] snap;
    logic [3:0] q_saved;

    initial begin
        // Reset with clock running
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(out_vec()), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        // Plain load
        run_cmd(2'b00, 1'b0, 3'd0, 4'b1010, 1'b0, lat, nenb, nbusy, snap);
        check("load_latency", 32'(lat), 32'd2);
        check("load_snap", 32'(snap), 32'({1'b1, 2'b11, 1'b0, 4'b1010}));
        check("load_enb_cycles", 32'(nenb), 32'd1);
        check("load_q", 32'(q), 32'b1010);

        // Load then two left shifts with fill 0
        run_cmd(2'b10, 1'b0, 3'd2, 4'b1011, 1'b0, lat, nenb, nbusy, snap);
        check("ldsh_latency", 32'(lat), 32'd4);
        check("ldsh_busy_cycles", 32'(nbusy), 32'd4);
        check("ldsh_enb_cycles", 32'(nenb), 32'd3);
        check("ldsh_snap", 32'(snap), 32'({1'b1, 2'b11, 1'b0, 4'b1011}));
        check("ldsh_q", 32'(q), 32'b1100);

        // Rotate right by 3 from 0001
        run_cmd(2'b00, 1'b0, 3'd0, 4'b0001, 1'b0, lat, nenb, nbusy, snap);
        run_cmd(2'b11, 1'b1, 3'd3, 4'b1111, 1'b0, lat, nenb, nbusy, snap);
        check("rotr3_latency", 32'(lat), 32'd4);
        check("rotr3_snap", 32'(snap), 32'({1'b1, 2'b10, 1'b1, 4'b0000}));
        check("rotr3_q", 32'(q), 32'b0010);

        // Rotate left by 4 is identity; rotate left by 7 equals rotate left 3
        run_cmd(2'b00, 1'b0, 3'd0, 4'b0110, 1'b0, lat, nenb, nbusy, snap);
        run_cmd(2'b11, 1'b0, 3'd4, 4'b0000, 1'b1, lat, nenb, nbusy, snap);
        check("rotl4_latency", 32'(lat), 32'd5);
        check("rotl4_q", 32'(q), 32'b0110);
        run_cmd(2'b11, 1'b0, 3'd7, 4'b0000, 1'b1, lat, nenb, nbusy, snap);
        check("rotl7_latency", 32'(lat), 32'd8);
        check("rotl7_q", 32'(q), 32'b0011);

        // Right shift by 3 with fill 1: 0011 -> 1001 -> 1100 -> 1110
        run_cmd(2'b01, 1'b1, 3'd3, 4'b0000, 1'b1, lat, nenb, nbusy, snap);
        check("shr3_latency", 32'(lat), 32'd4);
        check("shr3_snap", 32'(snap), 32'({1'b1, 2'b10, 1'b1, 4'b0000}));
        check("shr3_q", 32'(q), 32'b1110);

        // Zero-count shift: no enable, DONE right after accept
        run_cmd(2'b01, 1'b0, 3'd0, 4'b0000, 1'b1, lat, nenb, nbusy, snap);
        check("cnt0_latency", 32'(lat), 32'd1);
        check("cnt0_enb_cycles", 32'(nenb), 32'd0);
        check("cnt0_q", 32'(q), 32'b1110);

        // Back-to-back with CMD_VALID held: accepts only on IDLE cycles
        cmd_op = 2'b01; cmd_dir = 1'b1; cmd_cnt = 3'd2; cmd_fill = 1'b0;
        cmd_valid = 1'b1;
        acc = 0; dn = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_valid && cmd_ready) acc++;
            if (done) dn++;
            if (busy && cmd_ready) bad++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd3);
        check("b2b_dones", 32'(dn), 32'd3);
        check("b2b_ready_while_busy", 32'(bad), 32'd0);
        check("b2b_q", 32'(q), 32'b0000);

        // Reset asserted in the middle of a shift
        @(posedge clk); #1;
        check("idle_before_abort", 32'(cmd_ready), 32'd1);
        cmd_op = 2'b01; cmd_dir = 1'b0; cmd_cnt = 3'd5; cmd_fill = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_shift", 32'({enb, modo, s_in}), 32'({1'b1, 2'b01, 1'b1}));
        q_saved = q;
        #2 reset = 1'b1;
        #1;
        check("abort_outputs_async", 32'(out_vec()), 32'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_q_kept", 32'(q), 32'(q_saved));
        reset = 1'b0;
        #1;
        check("ready_after_abort", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
